conway_grid_ctrl: RTL and testbench



---
 rtl/conway_grid_ctrl.sv | 149 ++++++++++++++
 tb/tb_conway_grid_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conway_grid_ctrl.sv
// Generation sequencer for a toroidal Game-of-Life grid. Two bit banks ping-pong between
// current and next generation, and every cell is evaluated by one shared external evaluator.
module conway_grid_ctrl #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [15:0]   gen_count,
    input  logic          wr_en,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic          wr_data,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic          rd_data,
    output logic [8:0]    cell_status,
    input  logic          cell_out
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int KW = $clog2(N);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_SWAP  = 2'd3;

    logic [N-1:0]  r_bank [2];
    logic          r_sel;
    logic [1:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [KW-1:0] r_k_prev;
    logic          r_wb_valid;
    logic          r_done;
    logic [15:0]   r_gen_cnt;

    logic [N-1:0]  w_cur;
    logic [XW-1:0] w_xm;
    logic [XW-1:0] w_xp;
    logic [YW-1:0] w_ym;
    logic [YW-1:0] w_yp;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [8:0]    w_status;

    function automatic logic [KW-1:0] f_idx(input logic [XW-1:0] fx, input logic [YW-1:0] fy);
        return KW'(32'(fy) * WIDTH + 32'(fx));
    endfunction

    assign w_cur = r_bank[r_sel];

    // Toroidal neighbour coordinates of the scan index
    assign w_xm = (r_x == '0)     ? X_LAST : r_x - XW'(1);
    assign w_xp = (r_x == X_LAST) ? '0     : r_x + XW'(1);
    assign w_ym = (r_y == '0)     ? Y_LAST : r_y - YW'(1);
    assign w_yp = (r_y == Y_LAST) ? '0     : r_y + YW'(1);

    assign w_wr_ok = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    assign w_rd_ok = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);

    always_comb begin
        w_status = '0;
        if (r_state == S_SCAN) begin
            w_status = {w_cur[f_idx(w_xm, w_ym)], w_cur[f_idx(r_x, w_ym)], w_cur[f_idx(w_xp, w_ym)],
                        w_cur[f_idx(w_xm, r_y)],  w_cur[f_idx(r_x, r_y)],  w_cur[f_idx(w_xp, r_y)],
                        w_cur[f_idx(w_xm, w_yp)], w_cur[f_idx(r_x, w_yp)], w_cur[f_idx(w_xp, w_yp)]};
        end
    end

    assign cell_status = w_status;
    assign rd_data     = w_rd_ok ? w_cur[f_idx(rd_x, rd_y)] : 1'b0;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign gen_count   = r_gen_cnt;

    // Sequencer: scan index, write-back pipeline, bank select and generation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_k_prev   <= '0;
            r_wb_valid <= 1'b0;
            r_done     <= 1'b0;
            r_sel      <= 1'b0;
            r_gen_cnt  <= '0;
        end else begin
            r_done     <= (r_state == S_SWAP);
            r_wb_valid <= (r_state == S_SCAN);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SCAN;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                S_SCAN: begin
                    r_k_prev <= f_idx(r_x, r_y);
                    if (r_x == X_LAST) begin
                        r_x <= '0;
                        if (r_y == Y_LAST) begin
                            r_y     <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_y <= r_y + YW'(1);
                        end
                    end else begin
                        r_x <= r_x + XW'(1);
                    end
                end
                S_DRAIN: r_state <= S_SWAP;
                S_SWAP: begin
                    r_sel     <= ~r_sel;
                    r_gen_cnt <= r_gen_cnt + 16'd1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Host writes hit the current bank only in IDLE; evaluator results land in the other bank
    // one cycle behind the scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else begin
            if (r_state == S_IDLE && wr_en && w_wr_ok) begin
                r_bank[r_sel][f_idx(wr_x, wr_y)] <= wr_data;
            end
            if (r_wb_valid) begin
                r_bank[~r_sel][r_k_prev] <= cell_out;
            end
        end
    end

endmodule

// File: tb/tb_conway_grid_ctrl.sv
// Self-checking bench for conway_grid_ctrl on a 5x5 torus with a behavioural Life evaluator
// and a grid-level reference model.
module tb_conway_grid_ctrl;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int XW = 3;
    localparam int YW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_data = 1'b0;
    logic          cell_out = 1'b0;
    logic [XW-1:0] wr_x = '0;
    logic [YW-1:0] wr_y = '0;
    logic [XW-1:0] rd_x = '0;
    logic [YW-1:0] rd_y = '0;
    logic          busy;
    logic          done;
    logic          rd_data;
    logic [15:0]   gen_count;
    logic [8:0]    cell_status;

    int          checks = 0;
    int          errors = 0;
    bit          model     [H][W];
    bit          nxt_model [H][W];
    logic [15:0] exp_gen = '0;

    conway_grid_ctrl #(.WIDTH(W), .HEIGHT(H)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .gen_count  (gen_count),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_data    (rd_data),
        .cell_status(cell_status),
        .cell_out   (cell_out)
    );

    always #5 clk = ~clk;

    // Life rule applied to a neighbourhood word ([4] is the centre cell)
    function automatic bit life(input logic [8:0] s);
        int n;
        n = 0;
        for (int i = 0; i < 9; i++) if (i != 4 && s[i] === 1'b1) n++;
        return (n == 3) || (s[4] === 1'b1 && n == 2);
    endfunction

    always @(posedge clk) cell_out <= life(cell_status);

    function automatic bit [8:0] exp_status(input int x, input int y);
        int xm, xp, ym, yp;
        xm = (x + W - 1) % W;
        xp = (x + 1) % W;
        ym = (y + H - 1) % H;
        yp = (y + 1) % H;
        return {model[ym][xm], model[ym][x], model[ym][xp],
                model[y][xm],  model[y][x],  model[y][xp],
                model[yp][xm], model[yp][x], model[yp][xp]};
    endfunction

    task automatic compute_next();
        int n;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dy != 0 || dx != 0) n += int'(model[(y + dy + H) % H][(x + dx + W) % W]);
                nxt_model[y][x] = (n == 3) || (model[y][x] && n == 2);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) model[y][x] = 1'b0;
        exp_gen = '0;
    endtask

    task automatic load_cell(input int x, input int y, input bit v);
        @(negedge clk);
        wr_en = 1'b1;
        wr_x = XW'(x);
        wr_y = YW'(y);
        wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
        if (x < W && y < H) model[y][x] = v;
    endtask

    task automatic check_grid(input string name);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                rd_x = XW'(x);
                rd_y = YW'(y);
                #1;
                checks++;
                if (rd_data !== model[y][x]) begin
                    errors++;
                    $display("FAIL %s rd(%0d,%0d) got %b want %b", name, x, y, rd_data, model[y][x]);
                end
            end
        end
        @(negedge clk);
    endtask

    // One generation; optionally pulses start+wr_en(1,1) at SCAN cycle `inject`
    task automatic run_gen(input int inject, input string name, output logic [8:0] first_s);
        int         busy_cyc;
        int         done_at;
        logic [8:0] want;
        compute_next();
        first_s = 'x;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0;
        done_at = -1;
        for (int c = 0; c < N + 40; c++) begin
            if (c == inject) begin
                start = 1'b1;
                wr_en = 1'b1;
                wr_x = XW'(1);
                wr_y = YW'(1);
                wr_data = ~model[1][1];
            end
            if (c == inject + 1) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (c == 0) first_s = cell_status;
            want = (c < N) ? exp_status(c % W, c / W) : 9'd0;
            if (c < N + 2) begin
                checks++;
                if (cell_status !== want) begin
                    errors++;
                    $display("FAIL %s status c=%0d got %b want %b", name, c, cell_status, want);
                end
            end
            if (c == N / 2) begin
                rd_x = XW'(1);
                rd_y = YW'(1);
                #1;
                checks++;
                if (rd_data !== model[1][1]) begin
                    errors++;
                    $display("FAIL %s rd_mid got %b want %b", name, rd_data, model[1][1]);
                end
            end
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (done_at != N + 2) begin
            errors++;
            $display("FAIL %s done_cycle got %0d want %0d", name, done_at, N + 2);
        end
        checks++;
        if (busy_cyc != N + 2) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cyc, N + 2);
        end
        model = nxt_model;
        exp_gen = exp_gen + 16'd1;
        if (done_at >= 0) begin
            rd_x = XW'(2);
            rd_y = YW'(2);
            #1;
            checks++;
            if (rd_data !== model[2][2]) begin
                errors++;
                $display("FAIL %s rd_at_done got %b want %b", name, rd_data, model[2][2]);
            end
        end
        checks++;
        if (gen_count !== exp_gen) begin
            errors++;
            $display("FAIL %s gen_count got %h want %h", name, gen_count, exp_gen);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done i=%0d got done=%b busy=%b want 0 0", name, i, done, busy);
            end
        end
    endtask

    task automatic load_blinker();
        load_cell(1, 2, 1'b1);
        load_cell(2, 2, 1'b1);
        load_cell(3, 2, 1'b1);
    endtask

    task automatic check_blinker(input string name, input bit vertical);
        bit want;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                want = vertical ? (x == 2 && y >= 1 && y <= 3) : (y == 2 && x >= 1 && x <= 3);
                rd_x = XW'(x);
                rd_y = YW'(y);
                #1;
                checks++;
                if (rd_data !== want) begin
                    errors++;
                    $display("FAIL %s (%0d,%0d) got %b want %b", name, x, y, rd_data, want);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0 || cell_status !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b gen=%h status=%b want 0 0 0000 0",
                     busy, done, gen_count, cell_status);
        end
        check_grid("reset_grid");
    endtask

    task automatic test_blinker();
        logic [8:0] fs;
        do_reset();
        load_blinker();
        run_gen(-1, "blinker1", fs);
        check_blinker("blinker_vertical", 1'b1);
        run_gen(-1, "blinker2", fs);
        check_blinker("blinker_horizontal", 1'b0);
        checks++;
        if (gen_count !== 16'd2) begin
            errors++;
            $display("FAIL blinker_gen_count got %h want 0002", gen_count);
        end
    endtask

    task automatic test_wrap_block();
        logic [8:0] fs;
        do_reset();
        load_cell(0, 0, 1'b1);
        load_cell(4, 0, 1'b1);
        load_cell(0, 4, 1'b1);
        load_cell(4, 4, 1'b1);
        run_gen(-1, "wrap1", fs);
        checks++;
        // NW(4,4) N(0,4) W(4,0) C(0,0) alive; all others dead
        if (fs !== 9'b110110000) begin
            errors++;
            $display("FAIL wrap_first_status got %b want %b", fs, 9'b110110000);
        end
        run_gen(-1, "wrap2", fs);
        run_gen(-1, "wrap3", fs);
        check_grid("wrap_grid");
        for (int i = 0; i < 4; i++) begin
            rd_x = XW'((i % 2) * 4);
            rd_y = YW'((i / 2) * 4);
            #1;
            checks++;
            if (rd_data !== 1'b1) begin
                errors++;
                $display("FAIL wrap_corner%0d got %b want 1", i, rd_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lone_cell();
        logic [8:0] fs;
        do_reset();
        load_cell(2, 2, 1'b1);
        run_gen(-1, "lone", fs);
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) model[y][x] = 1'b0;
        check_grid("lone_grid");
    endtask

    task automatic test_ignored();
        logic [8:0] fs;
        do_reset();
        load_blinker();
        run_gen(5, "ignored", fs);
        check_grid("ignored_grid");
        checks++;
        if (gen_count !== 16'd1) begin
            errors++;
            $display("FAIL ignored_gen_count got %h want 0001", gen_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] fs;
        do_reset();
        load_blinker();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b done=%b gen=%h want 0 0 0000",
                     busy, done, gen_count);
        end
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) model[y][x] = 1'b0;
        exp_gen = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet i=%0d got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        check_grid("midreset_grid");
        load_blinker();
        run_gen(-1, "midreset_blinker", fs);
        check_blinker("midreset_vertical", 1'b1);
    endtask

    task automatic test_out_of_range();
        do_reset();
        load_cell(0, 1, 1'b1);
        load_cell(5, 0, 1'b1);
        load_cell(0, 5, 1'b1);
        load_cell(7, 7, 1'b1);
        load_cell(6, 2, 1'b1);
        check_grid("oor_grid");
        for (int i = 0; i < 4; i++) begin
            rd_x = (i == 0) ? XW'(5) : (i == 1) ? XW'(6) : (i == 2) ? XW'(0) : XW'(7);
            rd_y = (i == 0) ? YW'(0) : (i == 1) ? YW'(0) : (i == 2) ? YW'(5) : YW'(7);
            #1;
            checks++;
            if (rd_data !== 1'b0) begin
                errors++;
                $display("FAIL oor_read%0d got %b want 0", i, rd_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [8:0] fs;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            for (int k = 0; k < 14; k++) begin
                load_cell(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          bit'($urandom_range(0, 1)));
            end
            check_grid("rand_seed");
            run_gen(-1, "rand_gen1", fs);
            run_gen(-1, "rand_gen2", fs);
            check_grid("rand_grid");
        end
    endtask

    task automatic test_gen_wrap();
        logic [8:0] fs;
        @(negedge clk);
        force u_dut.r_gen_cnt = 16'hFFFE;
        @(negedge clk);
        release u_dut.r_gen_cnt;
        exp_gen = 16'hFFFE;
        @(negedge clk);
        checks++;
        if (gen_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_preset got %h want fffe", gen_count);
        end
        run_gen(-1, "gen_ffff", fs);
        run_gen(-1, "gen_0000", fs);
        checks++;
        if (gen_count !== 16'h0000) begin
            errors++;
            $display("FAIL gen_wrap got %h want 0000", gen_count);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_blinker();
        test_wrap_block();
        test_lone_cell();
        test_ignored();
        test_reset_mid();
        test_out_of_range();
        test_random();
        test_gen_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
